// File: rtl/instruction_fetch_ctrl.sv
// rtl/instruction_fetch_ctrl.sv - fetch PC generator, in-order memory requester and credit-bounded response queue
// Optional feature macro: MIST1032ISA_FETCH_PERF_COUNTER_EN (adds fetch/discard counters)
module instruction_fetch_ctrl #(
  parameter int          P_DEPTH    = 4,
  parameter int          P_DEPTH_N  = 2,
  parameter logic [31:0] P_RESET_PC = 32'h0
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iEVENT_START,
  input  logic [31:0] iEVENT_PC,
  input  logic        iBRANCH_VALID,
  input  logic [31:0] iBRANCH_PC,
  input  logic        iPAGING_ENA,
  input  logic        iKERNEL_ACCESS,
  output logic        oMEM_REQ,
  output logic [31:0] oMEM_ADDR,
  input  logic        iMEM_BUSY,
  input  logic        iMEM_VALID,
  input  logic [31:0] iMEM_DATA,
  input  logic [11:0] iMEM_MMU_FLAGS,
  output logic        oNEXT_INST_VALID,
  output logic [11:0] oNEXT_MMU_FLAGS,
  output logic        oNEXT_PAGING_ENA,
  output logic        oNEXT_KERNEL_ACCESS,
  output logic        oNEXT_BRANCH_PREDICT,
  output logic [31:0] oNEXT_BRANCH_PREDICT_ADDR,
  output logic [31:0] oNEXT_INST,
  output logic [31:0] oNEXT_PC,
  input  logic        iNEXT_FETCH_STOP,
  input  logic        iNEXT_LOCK
`ifdef MIST1032ISA_FETCH_PERF_COUNTER_EN
  ,
  output logic [31:0] oPERF_FETCH_COUNT,
  output logic [31:0] oPERF_DISCARD_COUNT
`endif
);

  localparam int CW = P_DEPTH_N + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(P_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} fetchStateT;

  fetchStateT           state;
  logic [31:0]          fetchPc;
  logic [31:0]          rspPc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        discard;
  logic [CW-1:0]        qCount;
  logic [P_DEPTH_N-1:0] wrPtr;
  logic [P_DEPTH_N-1:0] rdPtr;

  logic [11:0]          qFlags  [P_DEPTH];
  logic                 qPaging [P_DEPTH];
  logic                 qKernel [P_DEPTH];
  logic [31:0]          qInst   [P_DEPTH];
  logic [31:0]          qPc     [P_DEPTH];

  logic                 active;
  logic                 restart;
  logic [31:0]          targetPc;
  logic [CW:0]          creditUsed;
  logic                 memReq;
  logic                 accept;
  logic                 rspIn;
  logic                 rspDrop;
  logic                 push;
  logic                 pop;
  logic                 headValid;
  logic [CW-1:0]        outAfterRsp;

  // Issue, drop and pop decisions for the current cycle; a restart squashes issue and pop
  always_comb begin
    active      = (state != IDLE);
    restart     = active && (iEVENT_START || iBRANCH_VALID) && !iRESET_SYNC;
    targetPc    = iEVENT_START ? {iEVENT_PC[31:2], 2'b00} : {iBRANCH_PC[31:2], 2'b00};
    creditUsed  = {1'b0, outstanding} + {1'b0, qCount};
    memReq      = active && !iRESET_SYNC && !restart && !iNEXT_FETCH_STOP && (creditUsed < DEPTH_L);
    accept      = memReq && !iMEM_BUSY;
    rspIn       = active && !iRESET_SYNC && iMEM_VALID;
    rspDrop     = rspIn && (restart || (state == DRAIN));
    push        = rspIn && !rspDrop;
    headValid   = (qCount != '0);
    pop         = headValid && !iNEXT_LOCK && !restart && !iRESET_SYNC;
    outAfterRsp = outstanding - {{(CW-1){1'b0}}, rspIn};
  end

  // Control FSM, fetch/response PCs, credit counters and queue pointers
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state       <= IDLE;
      fetchPc     <= P_RESET_PC;
      rspPc       <= P_RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      qCount      <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
    end else if (iRESET_SYNC) begin
      state       <= IDLE;
      fetchPc     <= P_RESET_PC;
      rspPc       <= P_RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      qCount      <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
    end else begin
      if (state == IDLE) begin
        if (iEVENT_START) begin
          state   <= RUN;
          fetchPc <= {iEVENT_PC[31:2], 2'b00};
          rspPc   <= {iEVENT_PC[31:2], 2'b00};
        end
      end else if (restart) begin
        fetchPc <= targetPc;
        rspPc   <= targetPc;
        discard <= outAfterRsp;
        state   <= (outAfterRsp != '0) ? DRAIN : RUN;
      end else begin
        if (accept) fetchPc <= fetchPc + 32'd4;
        if (push) rspPc <= rspPc + 32'd4;
        if ((state == DRAIN) && rspIn) begin
          discard <= discard - {{(CW-1){1'b0}}, 1'b1};
          if (discard == {{(CW-1){1'b0}}, 1'b1}) state <= RUN;
        end
      end

      outstanding <= outAfterRsp + {{(CW-1){1'b0}}, accept};

      if (restart) begin
        qCount <= '0;
        wrPtr  <= '0;
        rdPtr  <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + {{(P_DEPTH_N-1){1'b0}}, 1'b1};
        if (pop) rdPtr <= rdPtr + {{(P_DEPTH_N-1){1'b0}}, 1'b1};
        qCount <= qCount + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
    end
  end

  // Queue payload storage; contents are only meaningful below qCount so no reset is needed
  always_ff @(posedge iCLOCK) begin
    if (push) begin
      qFlags[wrPtr]  <= iMEM_MMU_FLAGS;
      qPaging[wrPtr] <= iPAGING_ENA;
      qKernel[wrPtr] <= iKERNEL_ACCESS;
      qInst[wrPtr]   <= iMEM_DATA;
      qPc[wrPtr]     <= rspPc;
    end
  end

  assign oMEM_REQ                  = memReq;
  assign oMEM_ADDR                 = active ? fetchPc : 32'h0;
  assign oNEXT_INST_VALID          = pop;
  assign oNEXT_MMU_FLAGS           = headValid ? qFlags[rdPtr] : 12'h0;
  assign oNEXT_PAGING_ENA          = headValid ? qPaging[rdPtr] : 1'b0;
  assign oNEXT_KERNEL_ACCESS       = headValid ? qKernel[rdPtr] : 1'b0;
  assign oNEXT_INST                = headValid ? qInst[rdPtr] : 32'h0;
  assign oNEXT_PC                  = headValid ? qPc[rdPtr] : 32'h0;
  assign oNEXT_BRANCH_PREDICT      = 1'b0;
  assign oNEXT_BRANCH_PREDICT_ADDR = 32'h0;

`ifdef MIST1032ISA_FETCH_PERF_COUNTER_EN
  logic [31:0] perfFetch;
  logic [31:0] perfDiscard;

  // Saturating counts of queued and dropped responses
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      perfFetch   <= '0;
      perfDiscard <= '0;
    end else if (iRESET_SYNC) begin
      perfFetch   <= '0;
      perfDiscard <= '0;
    end else begin
      if (push && (perfFetch != 32'hFFFF_FFFF)) perfFetch <= perfFetch + 32'd1;
      if (rspDrop && (perfDiscard != 32'hFFFF_FFFF)) perfDiscard <= perfDiscard + 32'd1;
    end
  end

  assign oPERF_FETCH_COUNT   = perfFetch;
  assign oPERF_DISCARD_COUNT = perfDiscard;
`endif

endmodule
